// File: rtl/sta_pkg.sv
// Shared types and PRBS7 (x^7+x^6+1) constants for the timing-path test structure.
package sta_pkg;

   typedef enum logic [1:0] {IDLE, SEED, CHECK, LOCKED} sta_chk_state_t;

   localparam int PRBS7_W      = 7;
   localparam int PRBS7_TAP_HI = 6;
   localparam int PRBS7_TAP_LO = 5;

endpackage

// File: rtl/sta_prbs7_lfsr.sv
// PRBS7 shift register: shifts i_din in at the LSB end, o_pred is the next expected bit.
// Shared between the capture checker and the launch-side generator.
module sta_prbs7_lfsr
   import sta_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_shift_en,
   input  logic i_din,
   output logic o_pred,
   output logic o_next_zero
);

   logic [PRBS7_W-1:0] r_lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= '0;
      end else if (i_clr) begin
         r_lfsr <= '0;
      end else if (i_shift_en) begin
         r_lfsr <= {r_lfsr[PRBS7_W-2:0], i_din};
      end
   end

   assign o_pred = r_lfsr[PRBS7_TAP_HI] ^ r_lfsr[PRBS7_TAP_LO];

   // Flags the all-zero lock-up state the register would hold after this shift.
   assign o_next_zero = ({r_lfsr[PRBS7_W-2:0], i_din} == '0);

endmodule

// File: rtl/sta_capture_checker.sv
// Capture end of the timing-path test: registers rx_bit, self-syncs a PRBS7 checker, counts errors.
// Optional STA_CHK_ERR_INJECT_EN adds inj_err, which inverts the captured bit before use.
module sta_capture_checker
   import sta_pkg::*;
#(
   parameter int SYNC_LEN = 8,
   parameter int LOSS_RUN = 4,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_bit,
   input  logic             en,
   input  logic             clear,
`ifdef STA_CHK_ERR_INJECT_EN
   input  logic             inj_err,
`endif
   output logic             locked,
   output logic             err_flag,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] bit_cnt
);

   localparam logic [2:0]       SEED_LAST  = 3'(PRBS7_W - 1);
   localparam logic [7:0]       MATCH_LAST = 8'(SYNC_LEN - 1);
   localparam logic [3:0]       MISS_LAST  = 4'(LOSS_RUN - 1);
   localparam logic [ERR_W-1:0] CNT_MAX    = {ERR_W{1'b1}};

   sta_chk_state_t   r_state;
   logic             r_cap_q;
   logic [2:0]       r_seed_cnt;
   logic [7:0]       r_match_cnt;
   logic [3:0]       r_miss_run;
   logic             r_locked;
   logic             r_err_flag;
   logic [ERR_W-1:0] r_err_cnt;
   logic [ERR_W-1:0] r_bit_cnt;

   logic w_bit;
   logic w_pred;
   logic w_next_zero;
   logic w_din;
   logic w_shift_en;
   logic w_miss;
   logic w_count;

`ifdef STA_CHK_ERR_INJECT_EN
   assign w_bit = r_cap_q ^ inj_err;
`else
   assign w_bit = r_cap_q;
`endif

   // Once locked the register free-runs on its own prediction, so a line error counts once.
   assign w_din      = (r_state == LOCKED) ? w_pred : w_bit;
   assign w_shift_en = en && (r_state != IDLE);
   assign w_miss     = (w_bit != w_pred);
   assign w_count    = en && (r_state == LOCKED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cap_q <= 1'b0;
      end else begin
         r_cap_q <= rx_bit;
      end
   end

   sta_prbs7_lfsr u_lfsr (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (!en),
      .i_shift_en  (w_shift_en),
      .i_din       (w_din),
      .o_pred      (w_pred),
      .o_next_zero (w_next_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_seed_cnt  <= '0;
         r_match_cnt <= '0;
         r_miss_run  <= '0;
         r_locked    <= 1'b0;
      end else if (!en) begin
         r_state     <= IDLE;
         r_seed_cnt  <= '0;
         r_match_cnt <= '0;
         r_miss_run  <= '0;
         r_locked    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state    <= SEED;
               r_seed_cnt <= '0;
            end
            SEED: begin
               if (r_seed_cnt == SEED_LAST) begin
                  r_seed_cnt <= '0;
                  if (!w_next_zero) begin
                     r_state     <= CHECK;
                     r_match_cnt <= '0;
                  end
               end else begin
                  r_seed_cnt <= r_seed_cnt + 3'd1;
               end
            end
            CHECK: begin
               if (w_miss) begin
                  r_match_cnt <= '0;
               end else if (r_match_cnt == MATCH_LAST) begin
                  r_state     <= LOCKED;
                  r_locked    <= 1'b1;
                  r_match_cnt <= '0;
                  r_miss_run  <= '0;
               end else begin
                  r_match_cnt <= r_match_cnt + 8'd1;
               end
            end
            LOCKED: begin
               if (!w_miss) begin
                  r_miss_run <= '0;
               end else if (r_miss_run == MISS_LAST) begin
                  r_state    <= SEED;
                  r_locked   <= 1'b0;
                  r_seed_cnt <= '0;
                  r_miss_run <= '0;
               end else begin
                  r_miss_run <= r_miss_run + 4'd1;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   // Clear has priority over a same-cycle increment; counts saturate rather than wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_err_flag <= 1'b0;
      end else if (clear) begin
         r_err_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_err_flag <= 1'b0;
      end else if (w_count) begin
         if (r_bit_cnt != CNT_MAX) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_miss) begin
            r_err_flag <= 1'b1;
            if (r_err_cnt != CNT_MAX) begin
               r_err_cnt <= r_err_cnt + 1'b1;
            end
         end
      end
   end

   assign locked   = r_locked;
   assign err_flag = r_err_flag;
   assign err_cnt  = r_err_cnt;
   assign bit_cnt  = r_bit_cnt;

endmodule

// File: tb/tb_sta_capture_checker.sv
// Directed bench for sta_capture_checker: a 16-bit and a 4-bit counter instance share one PRBS7 stream.
module tb_sta_capture_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_bit;
   logic        en;
   logic        clear;
`ifdef STA_CHK_ERR_INJECT_EN
   logic        inj_err;
`endif
   logic        locked;
   logic        err_flag;
   logic [15:0] err_cnt;
   logic [15:0] bit_cnt;
   logic        locked4;
   logic        err_flag4;
   logic [3:0]  err_cnt4;
   logic [3:0]  bit_cnt4;

   int n_cmp = 0;
   int n_bad = 0;
   int idx   = 0;
   int mode  = 0;   // 0: clean PRBS7, 1: inverted bit, 2: forced zero
   logic prbs [0:126];

   always #5 clk = ~clk;

   sta_capture_checker #(.SYNC_LEN(8), .LOSS_RUN(4), .ERR_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_bit   (rx_bit),
      .en       (en),
      .clear    (clear),
`ifdef STA_CHK_ERR_INJECT_EN
      .inj_err  (inj_err),
`endif
      .locked   (locked),
      .err_flag (err_flag),
      .err_cnt  (err_cnt),
      .bit_cnt  (bit_cnt)
   );

   sta_capture_checker #(.SYNC_LEN(8), .LOSS_RUN(4), .ERR_W(4)) dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_bit   (rx_bit),
      .en       (en),
      .clear    (clear),
`ifdef STA_CHK_ERR_INJECT_EN
      .inj_err  (1'b0),
`endif
      .locked   (locked4),
      .err_flag (err_flag4),
      .err_cnt  (err_cnt4),
      .bit_cnt  (bit_cnt4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive bit idx of the stream, take one edge, sample 1 ns after it.
   task automatic tick();
      case (mode)
         0:       rx_bit = prbs[idx % 127];
         1:       rx_bit = ~prbs[idx % 127];
         default: rx_bit = 1'b0;
      endcase
      @(posedge clk);
      #1;
      idx++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int n = 0; n < 7; n++) prbs[n] = 1'b1;
      for (int n = 7; n < 127; n++) prbs[n] = prbs[n-7] ^ prbs[n-6];

      rst_n  = 1'b0;
      en     = 1'b0;
      clear  = 1'b0;
      rx_bit = 1'b0;
`ifdef STA_CHK_ERR_INJECT_EN
      inj_err = 1'b0;
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_locked",   32'(locked),   32'd0);
      chk("rst_err_flag", 32'(err_flag), 32'd0);
      chk("rst_err_cnt",  32'(err_cnt),  32'd0);
      chk("rst_bit_cnt",  32'(bit_cnt),  32'd0);

      // Lock acquisition: 1 edge to SEED, 7 seed shifts, 8 matches.
      rst_n = 1'b1;
      en    = 1'b1;
      idx   = 0;
      repeat (15) tick();
      chk("lock_edge15", 32'(locked), 32'd0);
      tick();
      chk("lock_edge16", 32'(locked),  32'd1);
      chk("lock_errcnt", 32'(err_cnt), 32'd0);

      // Single flipped bit while locked.
      while (idx < 40) tick();
      mode = 1; tick(); mode = 0;
      tick();
      chk("flip_err_cnt",  32'(err_cnt),  32'd1);
      chk("flip_err_flag", 32'(err_flag), 32'd1);
      chk("flip_locked",   32'(locked),   32'd1);
      while (idx < 60) tick();
      chk("flip_after_cnt", 32'(err_cnt), 32'd1);

      // Stuck-at-0 over bits 127..130, all of which are 1 in the sequence.
      while (idx < 127) tick();
      mode = 2;
      repeat (4) tick();
      mode = 0;
      chk("stuck_3miss_locked", 32'(locked), 32'd1);
      tick();
      chk("stuck_drop_locked", 32'(locked),  32'd0);
      chk("stuck_err_cnt",     32'(err_cnt), 32'd5);
      chk("stuck_bit_cnt",     32'(bit_cnt), 32'd116);

      // Re-entry through SEED: 7 shifts then 8 matches.
      while (idx < 146) tick();
      chk("relock_before", 32'(locked), 32'd0);
      tick();
      chk("relock_locked",  32'(locked),  32'd1);
      chk("relock_bit_cnt", 32'(bit_cnt), 32'd116);
      chk("relock_err_cnt", 32'(err_cnt), 32'd5);

      // Asynchronous reset mid-stream.
      rst_n = 1'b0;
      #1;
      chk("midrst_locked",   32'(locked),   32'd0);
      chk("midrst_err_cnt",  32'(err_cnt),  32'd0);
      chk("midrst_bit_cnt",  32'(bit_cnt),  32'd0);
      chk("midrst_err_flag", 32'(err_flag), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (15) tick();
      chk("midrst_relock15", 32'(locked), 32'd0);
      tick();
      chk("midrst_relock16", 32'(locked), 32'd1);

      // Clear while locked, including the bit count increment of that edge.
      mode = 1; tick(); mode = 0;
      tick();
      chk("pre_clear_err", 32'(err_cnt), 32'd1);
      chk("pre_clear_bit", 32'(bit_cnt), 32'd2);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clear_err_cnt",  32'(err_cnt),  32'd0);
      chk("clear_bit_cnt",  32'(bit_cnt),  32'd0);
      chk("clear_err_flag", 32'(err_flag), 32'd0);
      tick();
      chk("clear_then_bit", 32'(bit_cnt), 32'd1);

      // en low drops to IDLE with counters held; constant zero never locks.
      en = 1'b0; tick();
      chk("en0_locked",  32'(locked),  32'd0);
      chk("en0_bit_cnt", 32'(bit_cnt), 32'd1);
      en = 1'b1;
      mode = 2;
      repeat (40) tick();
      chk("zero_locked",  32'(locked),  32'd0);
      chk("zero_err_cnt", 32'(err_cnt), 32'd0);
      chk("zero_bit_cnt", 32'(bit_cnt), 32'd1);

      // Bounded relock from the zero stream.
      mode = 0;
      for (int k = 0; k < 80; k++) begin
         if (locked) break;
         tick();
      end
      chk("zero_recover_locked", 32'(locked), 32'd1);

      // Twenty isolated errors: the 4-bit instance saturates at 15.
      clear = 1'b1; tick(); clear = 1'b0;
      repeat (20) begin
         mode = 1; tick();
         mode = 0; tick();
      end
      chk("sat_err_cnt16",  32'(err_cnt),   32'd20);
      chk("sat_bit_cnt16",  32'(bit_cnt),   32'd40);
      chk("sat_err_cnt4",   32'(err_cnt4),  32'd15);
      chk("sat_bit_cnt4",   32'(bit_cnt4),  32'd15);
      chk("sat_err_flag4",  32'(err_flag4), 32'd1);
      chk("sat_locked",     32'(locked),    32'd1);

      // Clear on the same edge that consumes a mismatch.
      mode = 1; tick(); mode = 0;
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clrwin_err_cnt16", 32'(err_cnt),  32'd0);
      chk("clrwin_err_cnt4",  32'(err_cnt4), 32'd0);
      chk("clrwin_err_flag",  32'(err_flag), 32'd0);
      tick();
      chk("clrwin_after_cnt",  32'(err_cnt),  32'd0);
      chk("clrwin_after_flag", 32'(err_flag), 32'd0);

`ifdef STA_CHK_ERR_INJECT_EN
      repeat (3) begin
         inj_err = 1'b1; tick();
         inj_err = 1'b0; tick();
      end
      chk("inj_err_cnt", 32'(err_cnt),  32'd3);
      chk("inj_locked",  32'(locked),   32'd1);
      chk("inj_other",   32'(err_cnt4), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
